// File: rtl/fmul_pkg.sv
// Shared FPU definitions for the multiply issue front-end.
//   FP_W      : IEEE single-precision word width
//   TAG_W_DEF : default destination-tag width (register index)
//   fmul_resp_t : one returned result, product plus destination tag
package fmul_pkg;

  localparam int FP_W      = 32;
  localparam int TAG_W_DEF = 5;

  typedef struct packed {
    logic [FP_W-1:0]      d;
    logic [TAG_W_DEF-1:0] tag;
  } fmul_resp_t;

endpackage

// File: rtl/fmul_res_fifo.sv
// Generic synchronous FIFO with an occupancy count and a registered head.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push/wdata : write request and data; the caller guarantees no push when full
//   pop        : read request; ignored while empty
//   rdata      : current head entry (meaningful only while count != 0)
//   count      : number of stored entries, 0..DEPTH
module fmul_res_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(push) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fmul_issue.sv
// Issue/return front-end for the fixed-latency FP32 multiplier.
//   req_valid/req_ready/req_s/req_t/req_tag : operation request handshake
//   mul_s/mul_t : operands straight to the multiplier (sampled every edge)
//   mul_d       : multiplier product, valid LAT cycles after the issue edge
//   resp_valid/resp_ready/resp_d/resp_tag   : in-order result handshake
//   idle        : nothing in flight and result FIFO empty
// The multiplier cannot stall, so an op is admitted only when a FIFO slot is
// reserved for it: in-flight ops plus buffered results never exceed RES_DEPTH.
module fmul_issue
  import fmul_pkg::*;
#(
  parameter int TAG_W     = TAG_W_DEF,
  parameter int LAT       = 1,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FP_W-1:0]  req_s,
  input  logic [FP_W-1:0]  req_t,
  input  logic [TAG_W-1:0] req_tag,
  output logic [FP_W-1:0]  mul_s,
  output logic [FP_W-1:0]  mul_t,
  input  logic [FP_W-1:0]  mul_d,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [FP_W-1:0]  resp_d,
  output logic [TAG_W-1:0] resp_tag,
  output logic             idle
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  logic [LAT-1:0]   trk_vld_q, trk_vld_d;
  logic [TAG_W-1:0] trk_tag_q [LAT];
  logic [TAG_W-1:0] trk_tag_d [LAT];
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic             issue;
  logic             fifo_push;
  logic             fifo_pop;
  logic [FP_W+TAG_W-1:0] fifo_head;
  logic [FP_W-1:0]  head_d;
  logic [TAG_W-1:0] head_tag;

  assign mul_s = req_s;
  assign mul_t = req_t;

  // Credits come from registered counts only, so a pop frees a slot one
  // cycle later and there is no resp_ready -> req_ready path.
  always_comb begin
    credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    req_ready   = !rst && (credit_used < (CW+1)'(RES_DEPTH));
    issue       = req_valid && req_ready;
    fifo_push   = trk_vld_q[LAT-1];
    trk_vld_d    = trk_vld_q;
    trk_vld_d[0] = issue;
    trk_tag_d    = trk_tag_q;
    trk_tag_d[0] = req_tag;
    for (int i = 1; i < LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_tag_d[i] = trk_tag_q[i-1];
    end
    inflight_d = inflight_q + CW'(issue) - CW'(fifo_push);
  end

  // Stage boundary: tracker follows the op through the multiplier pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q  <= '0;
      inflight_q <= '0;
    end else begin
      trk_vld_q  <= trk_vld_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    trk_tag_q <= trk_tag_d;
  end

  // Stage boundary: last tracker stage captures the product into the FIFO.
  fmul_res_fifo #(
    .WIDTH (FP_W + TAG_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({mul_d, trk_tag_q[LAT-1]}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign {head_d, head_tag} = fifo_head;

  // FIFO storage is not reset; outputs are forced to zero while empty.
  always_comb begin
    resp_valid = (fifo_count != '0);
    resp_d     = resp_valid ? head_d   : '0;
    resp_tag   = resp_valid ? head_tag : '0;
    fifo_pop   = resp_valid && resp_ready;
    idle       = (inflight_q == '0) && (fifo_count == '0);
  end

endmodule

// File: tb/tb_fmul_issue.sv
module tb_fmul_issue;
  import fmul_pkg::*;

  localparam int TAG_W     = TAG_W_DEF;
  localparam int LAT       = 1;
  localparam int RES_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_s, req_t;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      mul_s, mul_t, mul_d;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_d;
  logic [TAG_W-1:0] resp_tag;
  logic             idle;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  logic ovf_seen = 1'b0;

  fmul_resp_t sb_q[$];

  always #5 clk = ~clk;

  fmul_issue #(.TAG_W(TAG_W), .LAT(LAT), .RES_DEPTH(RES_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t), .req_tag(req_tag),
    .mul_s(mul_s), .mul_t(mul_t), .mul_d(mul_d),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_d(resp_d), .resp_tag(resp_tag), .idle(idle)
  );

  // Reference FP32 multiplier: truncating, denormals flushed to zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [47:0] m;
    logic [22:0] f;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if (ea == 8'hFF && a[22:0] != 0) return a | 32'h0040_0000;
    if (eb == 8'hFF && b[22:0] != 0) return b | 32'h0040_0000;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (a[30:0] == 0 || b[30:0] == 0) return 32'h7FC0_0000;
      return {s, 8'hFF, 23'd0};
    end
    if (ea == 0 || eb == 0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(ea) + int'(eb) - 127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 1;
    end else begin
      f = m[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], f};
  endfunction

  // Two-cycle multiplier: samples operands on one edge, product valid next cycle.
  always @(posedge clk) mul_d <= fmul(mul_s, mul_t);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] s, input logic [31:0] t, input int tag);
    req_valid = 1'b1;
    req_s     = s;
    req_t     = t;
    req_tag   = TAG_W'(tag);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (idle && sb_q.size() == 0) break;
    end
    check({tag, "_idle"}, idle, 1'b1);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  // Scoreboard monitor: push on accepted request, pop/compare on consumed result.
  logic        hold_v = 1'b0;
  logic [63:0] hold_val;
  always @(negedge clk) begin
    fmul_resp_t e;
    if (rst) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_vld", resp_valid, 1'b1);
        check("hold_data", {resp_tag, resp_d}, hold_val);
      end
      hold_v   = resp_valid && !resp_ready;
      hold_val = 64'({resp_tag, resp_d});
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_resp", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("resp_d", resp_d, e.d);
          check("resp_tag", resp_tag, e.tag);
          n_pops++;
        end
      end
      if (req_valid && req_ready) begin
        e.d   = fmul(req_s, req_t);
        e.tag = req_tag;
        sb_q.push_back(e);
      end
      if (dut.fifo_push && dut.fifo_count == RES_DEPTH) ovf_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int acc;
    logic [31:0] st_s [8];
    st_s = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
             32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};

    rst = 1'b1; req_valid = 1'b0; req_s = '0; req_t = '0; req_tag = '0;
    resp_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_d", resp_d, 32'h0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_idle", idle, 1'b1);
    step(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);

    // Single op 2.0 x 3.0, tag 3
    step(); drive(32'h4000_0000, 32'h4040_0000, 3);
    @(negedge clk);
    check("t1_issue", req_ready, 1'b1);
    check("t1_no_early", resp_valid, 1'b0);
    step(); req_valid = 1'b0;
    @(negedge clk);
    check("t1_lat1_novld", resp_valid, 1'b0);
    check("t1_busy", idle, 1'b0);
    step();
    @(negedge clk);
    check("t1_vld", resp_valid, 1'b1);
    check("t1_d", resp_d, 32'h40C0_0000);
    check("t1_tag", resp_tag, 3);
    step();
    @(negedge clk);
    check("t1_idle", idle, 1'b1);
    check("t1_vld_gone", resp_valid, 1'b0);

    // Streaming: 8 back-to-back ops
    p0 = n_pops;
    for (int k = 0; k < 8; k++) begin
      step(); drive(st_s[k], 32'h4000_0000, k);
      @(negedge clk);
      check("st_ready", req_ready, 1'b1);
    end
    step(); req_valid = 1'b0;
    wait_drain("st");
    check("st_count", n_pops - p0, 8);

    // Full / backpressure: 6 offered, 4 accepted
    resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      step(); drive(32'h4000_0000 + (acc << 16), 32'h3FC0_0000, 8 + acc);
      req_valid = (acc < 6);
      @(negedge clk);
      if (req_valid && req_ready) acc++;
    end
    check("full_acc", acc, 4);
    check("full_ready0", req_ready, 1'b0);
    check("full_head_vld", resp_valid, 1'b1);
    check("full_head_tag", resp_tag, 8);
    step(); resp_ready = 1'b1;
    @(negedge clk);
    check("full_no_comb_credit", req_ready, 1'b0);
    step(); resp_ready = 1'b0;
    drive(32'h4000_0000 + (acc << 16), 32'h3FC0_0000, 8 + acc);
    @(negedge clk);
    check("full_credit_back", req_ready, 1'b1);
    if (req_valid && req_ready) acc++;
    step(); req_valid = 1'b0;
    @(negedge clk);
    check("full_acc5", acc, 5);
    check("full_ready0_again", req_ready, 1'b0);
    resp_ready = 1'b1;
    wait_drain("full");

    // Simultaneous push and pop at count RES_DEPTH-1
    resp_ready = 1'b0;
    p0 = n_pops;
    for (int k = 0; k < 3; k++) begin
      step(); drive(32'h3F80_0000 + (k << 20), 32'h4040_0000, 16 + k);
    end
    step(); req_valid = 1'b0;
    step(); step();
    @(negedge clk);
    check("pp_cnt3", dut.fifo_count, 3);
    step(); drive(32'h4100_0000, 32'h4040_0000, 19);
    @(negedge clk);
    check("pp_issue", req_ready, 1'b1);
    step(); req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    check("pp_push_now", dut.fifo_push, 1'b1);
    step(); resp_ready = 1'b0;
    @(negedge clk);
    check("pp_cnt_same", dut.fifo_count, 3);
    resp_ready = 1'b1;
    wait_drain("pp");
    check("pp_pops", n_pops - p0, 4);

    // Reset mid-flight
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); drive(32'h4040_0000, 32'h4040_0000 + (k << 20), 24 + k);
      @(negedge clk);
      check("rm_issue", req_ready, 1'b1);
    end
    step(); req_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("rm_ready", req_ready, 1'b1);
    check("rm_idle", idle, 1'b1);
    check("rm_no_vld", resp_valid, 1'b0);
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    check("rm_still_no_vld", resp_valid, 1'b0);
    check("rm_still_idle", idle, 1'b1);

    // Special values pass straight through
    step(); drive(32'h7F80_0000, 32'h0000_0000, 30);
    step(); drive(32'h7FC0_0001, 32'h3F80_0000, 31);
    step(); req_valid = 1'b0;
    @(negedge clk);
    check("sp_inf0_vld", resp_valid, 1'b1);
    check("sp_inf0_d", resp_d, 32'h7FC0_0000);
    check("sp_inf0_tag", resp_tag, 30);
    step();
    @(negedge clk);
    check("sp_nan_d", resp_d, 32'h7FC0_0001);
    check("sp_nan_tag", resp_tag, 31);
    wait_drain("sp");

    check("no_push_when_full", ovf_seen, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmul_issue.md
Name: fmul_issue

Overview:
- Request/response front-end that wraps the two-cycle floating-point multiplier for the core's execute stage.
- Accepts operand pairs over a valid/ready handshake and drives them into the multiplier.
- Tracks in-flight operations with a valid/tag shift register and captures each product into a small result FIFO.
- Returns results in order, with destination tag, over a valid/ready handshake. The multiplier itself cannot stall, so the block admits work only when result storage is guaranteed (credit scheme).

Parameters:
- TAG_W, 5: width of the destination tag (register index) carried alongside each operation.
- LAT, 1: cycles from the issue edge to a valid product on mul_d. Must be ≥1; 1 matches the current multiplier.
- RES_DEPTH, 4: result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  upstream has an operation
- req_ready  out  1  block accepts the operation this cycle
- req_s  in  32  operand s, IEEE single
- req_t  in  32  operand t, IEEE single
- req_tag  in  TAG_W  destination tag
- mul_s  out  32  to multiplier s input
- mul_t  out  32  to multiplier t input
- mul_d  in  32  multiplier product
- resp_valid  out  1  result available
- resp_ready  in  1  downstream consumes result
- resp_d  out  32  product
- resp_tag  out  TAG_W  tag of resp_d
- idle  out  1  nothing in flight and FIFO empty

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: shift register valids 0, FIFO pointers/count 0, in-flight count 0. Resulting outputs: req_ready=0 during reset, resp_valid=0, resp_d=0, resp_tag=0, idle=1.
- Issue:
  - issue = req_valid && req_ready.
  - req_ready = !rst && (inflight + fifo_count) < RES_DEPTH. Computed from registered counts only; a same-cycle pop does NOT free a credit (no combinational resp_ready→req_ready path).
- Operand path: mul_s/mul_t = req_s/req_t combinationally, unconditionally. The multiplier samples them every edge; only the tracker decides which products are kept.
- Tracker: LAT-deep shift register of {vld, tag}. Stage 0 loads {issue, req_tag} each edge. When the last stage has vld=1, {mul_d, tag} is pushed into the FIFO on that edge.
- Latency: an op issued in cycle n has its product pushed at the end of cycle n+LAT. resp_valid is asserted in cycle n+LAT+1. There is no FIFO bypass, so minimum issue-to-resp_valid is LAT+1 cycles (2 by default).
- inflight: count of vld bits in the tracker.
  - +1 on issue, −1 on push; both in the same cycle leaves it unchanged.
  - Width clog2(RES_DEPTH)+1.
- FIFO:
  - Registered head: resp_valid = (fifo_count != 0); resp_d/resp_tag = head entry.
  - Pop on resp_valid && resp_ready.
  - Push and pop in the same cycle is legal at any occupancy; the count is unchanged.
  - Push when full cannot occur thanks to credits; the verification engineer asserts this.
  - Pointers wrap modulo RES_DEPTH.
- Backpressure: resp_valid, resp_d and resp_tag hold stable while resp_ready=0.
- Ordering: strictly in issue order.
- Full: with resp_ready held 0, exactly RES_DEPTH ops are accepted, then req_ready=0 until a pop occurs. req_ready returns the cycle after that pop.
- Reset mid-operation: all in-flight ops and buffered results are discarded. A product appearing on mul_d after reset is ignored, because the tracker valids are clear.
- idle = (inflight==0) && (fifo_count==0), registered-state based.
- Arithmetic: the block never inspects or modifies data. NaN, inf, zero and denormal handling stays in the multiplier.

Decomposition:
- Shared FPU package holds: FP32 width constant, TAG_W default, and a response struct/typedef {d[31:0], tag}.
- One natural sub-module: fmul_res_fifo, a generic synchronous FIFO with count output, parameterized by width and depth. Tracker and credit logic stay in fmul_issue.
- Bench instantiates fmul_issue together with the real two-cycle multiplier.

Test Plan:
- Single op: req 0x40000000 × 0x40400000, tag 3, issued at cycle 10 → resp_valid at cycle 12 with resp_d=0x40C00000, resp_tag=3; idle=1 at cycle 13 after pop.
- Streaming: 8 back-to-back ops (tags 0..7, s=k·1.0, t=2.0) with resp_ready=1 → req_ready stays 1, results arrive one per cycle in tag order 0..7 with correct products.
- Full/backpressure: resp_ready=0 and 6 ops offered → exactly 4 accepted, req_ready=0 afterward, resp data stable. Then raise resp_ready for one cycle → one pop, req_ready=1 next cycle, 5th op accepted.
- Simultaneous push/pop at count=RES_DEPTH−1: fifo_count unchanged, no loss or duplication, order preserved; no push-when-full assertion fires.
- Reset mid-flight: issue 3 ops, assert rst on the cycle after the 3rd issue → no resp_valid ever for those tags, idle=1, req_ready=1 the cycle after rst deasserts.
- Special values pass-through: 0x7F800000 × 0x00000000 and a NaN operand → resp_d equals the multiplier output bit-exactly, with correct tag.
